// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder block controller.
//   state_t : 3-bit FSM encodings (WAIT=0, TERMINATE=2, ENCODE=3)
//   ctrl_t  : bundle of the single-bit registered control outputs
//   DEF_*   : default parameter values; LTE_* : LTE code block bounds
package turbo_pkg;

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_TERM = 3'd2,
    ST_ENC  = 3'd3
  } state_t;

  typedef struct packed {
    logic enable;
    logic trellis_enable;
    logic switch_fb;
    logic clr;
    logic busy;
    logic done;
    logic len_err;
  } ctrl_t;

  localparam int LTE_MIN_LEN    = 40;
  localparam int LTE_MAX_LEN    = 6144;

  localparam int DEF_MAX_LEN    = LTE_MAX_LEN;
  localparam int DEF_TAIL_LEN   = 4;
  localparam int DEF_SWITCH_LEN = 1;
  localparam int DEF_LEN_W      = 13;

endpackage

// File: rtl/turbo_block_ctrl.sv
// Turbo encoder block sequencer: ENCODE for L cycles, then TERMINATE for
// TAIL_LEN cycles, with back-to-back restart, abort and error reporting.
// Ports:
//   clk, reset (async, active low)
//   data_valid, blk_len : start request and block length (sampled together)
//   abort               : synchronous abort of the block in flight
//   enable, trellis_enable, switch, clr : datapath strobes (registered)
//   current_state, bit_index, busy      : status (registered)
//   done, len_err                       : one-cycle event pulses
module turbo_block_ctrl
  import turbo_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int TAIL_LEN   = DEF_TAIL_LEN,
  parameter int SWITCH_LEN = DEF_SWITCH_LEN,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [LEN_W-1:0] blk_len,
  input  logic             abort,
  output logic             enable,
  output logic             trellis_enable,
  output logic             switch,
  output logic             clr,
  output logic [2:0]       current_state,
  output logic [LEN_W-1:0] bit_index,
  output logic             busy,
  output logic             done,
  output logic             len_err
);

  if (MAX_LEN < 1 || (2**LEN_W) <= MAX_LEN || TAIL_LEN < 2 ||
      SWITCH_LEN < 1 || SWITCH_LEN > TAIL_LEN) begin : g_bad_cfg
    $error("turbo_block_ctrl: illegal parameter combination");
  end

  localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] TAIL_LAST = LEN_W'(TAIL_LEN - 1);
  localparam logic [LEN_W-1:0] SW_L      = LEN_W'(SWITCH_LEN);

  state_t           state_q, state_d;
  ctrl_t            ctl_q, ctl_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             start_ok;
  logic             take_start;

  assign start_ok = (blk_len != '0) && (blk_len <= MAX_L);

  always_comb begin
    state_d    = ST_WAIT;
    len_d      = len_q;
    cnt_d      = '0;
    ctl_d      = '0;
    ctl_d.clr  = 1'b1;
    take_start = 1'b0;

    case (state_q)
      ST_WAIT: take_start = 1'b1;

      ST_ENC: begin
        if (!abort) begin
          ctl_d.clr  = 1'b0;
          ctl_d.busy = 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            // First tail cycle: bit_index 0 is always inside the switch window.
            state_d              = ST_TERM;
            ctl_d.trellis_enable = 1'b1;
            ctl_d.switch_fb      = 1'b1;
          end else begin
            state_d      = ST_ENC;
            cnt_d        = cnt_q + 1'b1;
            ctl_d.enable = 1'b1;
          end
        end
      end

      ST_TERM: begin
        if (!abort) begin
          if (cnt_q == TAIL_LAST) begin
            // Tail complete; this cycle can also accept the next block.
            ctl_d.done = 1'b1;
            take_start = 1'b1;
          end else begin
            state_d              = ST_TERM;
            cnt_d                = cnt_q + 1'b1;
            ctl_d.trellis_enable = 1'b1;
            ctl_d.switch_fb      = (cnt_q + 1'b1) < SW_L;
            ctl_d.clr            = 1'b0;
            ctl_d.busy           = 1'b1;
          end
        end
      end

      default: ;  // stray encodings fall back to WAIT with idle outputs
    endcase

    if (take_start && data_valid) begin
      if (start_ok) begin
        state_d      = ST_ENC;
        len_d        = blk_len;
        ctl_d.enable = 1'b1;
        ctl_d.clr    = 1'b0;
        ctl_d.busy   = 1'b1;
      end else begin
        ctl_d.len_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      len_q     <= '0;
      ctl_q     <= '0;
      ctl_q.clr <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ctl_q   <= ctl_d;
    end
  end

  assign enable         = ctl_q.enable;
  assign trellis_enable = ctl_q.trellis_enable;
  assign switch         = ctl_q.switch_fb;
  assign clr            = ctl_q.clr;
  assign busy           = ctl_q.busy;
  assign done           = ctl_q.done;
  assign len_err        = ctl_q.len_err;
  assign current_state  = state_q;
  assign bit_index      = cnt_q;

endmodule

// File: doc/turbo_block_ctrl.md
Name: turbo_block_ctrl

Overview:
Parametrised control FSM for the turbo encoder datapath. It sequences one code block through ENCODE and trellis TERMINATE phases, and drives the constituent-encoder enable, trellis termination, input switch and clear strobes. Unlike the fixed 1000/6000 controller, it:
- accepts any block length 1..MAX_LEN per block, latched at start;
- has a configurable tail length;
- exports the bit index for interleaver addressing;
- supports back-to-back blocks, abort, done/error reporting.

Parameters:
- MAX_LEN, 6144, largest legal block length in bits.
- TAIL_LEN, 4, TERMINATE phase length in cycles (>=2).
- SWITCH_LEN, 1, cycles at TERMINATE start during which switch is high (1..TAIL_LEN).
- LEN_W, 13, width of block length and bit counter; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data_valid  in  1  start request; sampled only in WAIT or last TERMINATE cycle.
- blk_len  in  LEN_W  block length; sampled with data_valid.
- abort  in  1  synchronous abort of current block.
- enable  out  1  constituent encoder shift enable.
- trellis_enable  out  1  trellis termination active.
- switch  out  1  input mux to feedback path.
- clr  out  1  encoder register clear.
- current_state  out  3  WAIT=0, ENCODE=3, TERMINATE=2.
- bit_index  out  LEN_W  phase counter (interleaver read address in ENCODE).
- busy  out  1  high whenever state != WAIT.
- done  out  1  one-cycle pulse, block fully terminated.
- len_err  out  1  one-cycle pulse, start rejected.

Behaviour:
- All outputs registered.
- Reset (reset=0, async): state=WAIT, bit_index=0, clr=1; enable, trellis_enable, switch, done, len_err and busy all 0. Reset mid-block discards the block; no done is issued.
- Legal start = data_valid & (1 <= blk_len <= MAX_LEN). The latched length L is held internally; blk_len changes mid-block are ignored.
- WAIT:
  - clr=1.
  - Legal start -> next cycle ENCODE: enable=1, clr=0, bit_index=0, busy=1.
  - data_valid with illegal length -> len_err=1 for one cycle, stay in WAIT.
- ENCODE:
  - bit_index increments every cycle; enable is high for exactly L cycles (bit_index 0..L-1).
  - At bit_index==L-1, next cycle TERMINATE: enable=0, trellis_enable=1, switch=1, clr=0, bit_index=0.
- TERMINATE:
  - bit_index counts 0..TAIL_LEN-1.
  - switch=1 while bit_index < SWITCH_LEN.
  - clr=0 during the phase, then returns to 1 on WAIT entry.
  - At bit_index==TAIL_LEN-1, next cycle: done=1 and trellis_enable=0. Then either:
    - legal start sampled in that same cycle -> ENCODE directly (enable=1, bit_index=0, new L, clr stays 0), i.e. zero gap cycles; or
    - otherwise -> WAIT (clr=1, busy=0).
  - Illegal start in that cycle -> len_err pulse plus WAIT.
- data_valid in ENCODE, or in TERMINATE before the last cycle, is ignored (no error).
- abort (ENCODE/TERMINATE): next cycle WAIT with clr=1, enable, trellis_enable and switch at 0, bit_index=0, no done. abort in WAIT has no effect. abort has priority over phase completion and over a back-to-back start.
- Counter arithmetic is unsigned LEN_W bits and never wraps, given the LEN_W constraint.
- Unused state encodings (1, 4-7) recover to WAIT with reset outputs on the next clock.

Decomposition:
- Shared package turbo_pkg:
  - state encodings WAIT/ENCODE/TERMINATE (3-bit);
  - default MAX_LEN, TAIL_LEN, SWITCH_LEN;
  - LTE length constants (40, 6144).
- No sub-module required; a single FSM with one shared counter is natural. Width and length checks belong in an elaboration-time assertion inside the module.

Test Plan:
- Reset: reset low with data_valid=1 -> state 0, clr=1, all other outputs 0. Release, blk_len=40, data_valid one cycle -> enable high exactly 40 cycles, bit_index 0..39.
- Tail (defaults): after 40-bit block -> trellis_enable high 4 cycles, switch high first cycle only, done one pulse on return to WAIT, busy high for 44 cycles total.
- Illegal lengths: blk_len=0 and blk_len=6145 with data_valid -> len_err pulse each, enable never rises, state stays 0.
- Back-to-back: data_valid+blk_len=6144 held in last TERMINATE cycle of a 40-bit block -> done and enable rise in the same cycle, zero gap, next enable lasts 6144 cycles.
- Abort: abort at bit_index=17 of a 1000-bit block -> next cycle WAIT, clr=1, no done, no trellis_enable. Abort in last TERMINATE cycle with data_valid -> WAIT, no new block.
- Async reset mid-TERMINATE: reset low at bit_index=2 -> outputs reach reset values before the next clk edge, no done pulse.
